// File: rtl/mult_div_unit_if.sv
// Bus between the register-file stage and the multiply/divide unit.
// The controller side drives operands, opcode and HI/LO moves; the unit returns status and HI/LO.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, srcA, srcB, mthi, mtlo, wdata,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, srcA, srcB, mthi, mtlo, wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle on magnitudes; signs are fixed up on the last step.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    mult_div_unit_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 done_q, done_d;
    logic                 dz_q, dz_d;

    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum, div_shift;
    logic                 div_ge, div_zero_c;
    logic [2*WIDTH-1:0]   acc_step, prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic signed_op);
        return (signed_op && x[WIDTH-1]) ? -x : x;
    endfunction

    assign sign_a = ~bus.op[0] & bus.srcA[WIDTH-1];
    assign sign_b = ~bus.op[0] & bus.srcB[WIDTH-1];
    assign mag_a  = magnitude(bus.srcA, ~bus.op[0]);
    assign mag_b  = magnitude(bus.srcB, ~bus.op[0]);

    // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        if (is_div_q) begin
            acc_step = {(div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // A zero divisor yields an all-ones quotient; the remainder naturally becomes the dividend.
    always_comb begin
        div_zero_c = is_div_q && (opnd_q == '0);
        prod_fix   = neg_res_q ? -acc_step : acc_step;
        rem_fix    = neg_rem_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
        quo_fix    = div_zero_c ? '1 : (neg_res_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0]);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    is_div_d  = bus.op[1];
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    opnd_d    = bus.op[1] ? mag_b : mag_a;
                    acc_d     = {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
                end else begin
                    if (bus.mthi) hi_d = bus.wdata;
                    if (bus.mtlo) lo_d = bus.wdata;
                end
            end
            RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    dz_d    = div_zero_c;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner vectors plus random ops
// compared against an arithmetic reference model.
module tb_mult_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    mult_div_unit_if #(.WIDTH(W)) bus();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        logic        ed;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] eh, output logic [31:0] el, output logic ed);
        logic [63:0] p;
        longint sa, sb;
        ed = 1'b0;
        eh = '0;
        el = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    eh = a; el = '1; ed = 1'b1;
                end else if (op == 2'd2) begin
                    el = 32'(sa / sb); eh = 32'(sa % sb);
                end else begin
                    el = a / b; eh = a % b;
                end
            end
        endcase
    endfunction

    // Launches one op in the current cycle and returns in the cycle done is seen (or after a bound).
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dz,
                         output int lat, output int busyc, output logic stable);
        logic [31:0] h0, l0;
        h0 = bus.hi;
        l0 = bus.lo;
        bus.start = 1'b1; bus.op = op; bus.srcA = a; bus.srcB = b;
        step();
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        bus.op = 2'($urandom); bus.srcA = $urandom; bus.srcB = $urandom;
        stable = (bus.hi === h0) && (bus.lo === l0);
        busyc = (bus.busy === 1'b1) ? 1 : 0;
        lat = 0;
        while (lat < 100) begin
            step();
            lat++;
            if (bus.done === 1'b1) break;
            if (bus.busy === 1'b1) busyc++;
            if (bus.hi !== h0 || bus.lo !== l0) stable = 1'b0;
        end
        hi = bus.hi;
        lo = bus.lo;
        dz = bus.div_zero;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.op = 2'd0; bus.srcA = '0; bus.srcB = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
        #1 reset = 1'b1;
        #2;
        total_cnt++;
        if ({bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo} !== '0)
            $display("FAIL reset_state got busy=%b done=%b dz=%b hi=%h lo=%h want all zero",
                     bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo);
        else pass_cnt++;
        step();
        step();
        reset = 1'b0;
        step();
        total_cnt++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== '0)
            $display("FAIL reset_release got busy=%b done=%b hi=%h lo=%h want all zero",
                     bus.busy, bus.done, bus.hi, bus.lo);
        else pass_cnt++;
    endtask

    task automatic test_vectors();
        vec_t v [0:8];
        logic [31:0] hi, lo;
        logic dz, stable;
        int lat, busyc;
        v[0] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        v[1] = '{2'd0, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        v[2] = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        v[3] = '{2'd3, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
        v[4] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        v[5] = '{2'd2, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        v[6] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        v[7] = '{2'd3, 32'hFFFFFFFF, 32'd7,        32'h00000003, 32'h24924924, 1'b0};
        v[8] = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        for (int i = 0; i < 9; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, hi, lo, dz, lat, busyc, stable);
            total_cnt++;
            if (hi !== v[i].eh || lo !== v[i].el || dz !== v[i].ed)
                $display("FAIL vec%0d_result got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                         i, hi, lo, dz, v[i].eh, v[i].el, v[i].ed);
            else pass_cnt++;
            total_cnt++;
            if (lat !== 32 || busyc !== 32 || stable !== 1'b1)
                $display("FAIL vec%0d_timing got lat=%0d busy=%0d stable=%b want 32 32 1",
                         i, lat, busyc, stable);
            else pass_cnt++;
            step();
            total_cnt++;
            if (bus.done !== 1'b0 || bus.div_zero !== 1'b0 || bus.hi !== v[i].eh || bus.lo !== v[i].el)
                $display("FAIL vec%0d_pulse got done=%b dz=%b hi=%h lo=%h want 0 0 %h %h",
                         i, bus.done, bus.div_zero, bus.hi, bus.lo, v[i].eh, v[i].el);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] hi, lo;
        logic dz, stable;
        int lat, busyc, stale;
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h55AA55AA;
        step();
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        bus.start = 1'b1; bus.op = 2'd1; bus.srcA = 32'd3; bus.srcB = 32'd5;
        step();
        bus.start = 1'b0;
        repeat (10) step();
        #1 reset = 1'b1;
        #1;
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0)
            $display("FAIL midrun_reset got busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        else pass_cnt++;
        @(posedge clk);
        #1 reset = 1'b0;
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) stale++;
        end
        total_cnt++;
        if (stale !== 0) $display("FAIL midrun_stale got %0d active cycles want 0", stale);
        else pass_cnt++;
        do_op(2'd1, 32'd6, 32'd7, hi, lo, dz, lat, busyc, stable);
        total_cnt++;
        if (hi !== 32'd0 || lo !== 32'd42 || lat !== 32)
            $display("FAIL midrun_rerun got hi=%h lo=%h lat=%0d want 0 2a 32", hi, lo, lat);
        else pass_cnt++;
        step();
    endtask

    task automatic test_start_while_busy();
        logic [31:0] h0;
        int lat;
        h0 = bus.hi;
        bus.start = 1'b1; bus.op = 2'd3; bus.srcA = 32'd1000; bus.srcB = 32'd7;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        bus.start = 1'b1; bus.op = 2'd1; bus.srcA = 32'd9; bus.srcB = 32'd9;
        bus.mthi = 1'b1; bus.wdata = 32'h1234;
        step();
        bus.start = 1'b0; bus.mthi = 1'b0;
        total_cnt++;
        if (bus.hi !== h0) $display("FAIL busy_mthi got hi=%h want %h", bus.hi, h0);
        else pass_cnt++;
        lat = 5;
        while (lat < 100 && bus.done !== 1'b1) begin
            step();
            lat++;
        end
        total_cnt++;
        if (lat !== 32 || bus.hi !== 32'd6 || bus.lo !== 32'd142)
            $display("FAIL busy_start got lat=%0d hi=%h lo=%h want 32 6 8e", lat, bus.hi, bus.lo);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL busy_no_restart got busy=%b want 0", bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_moves();
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hA5A5A5A5;
        step();
        total_cnt++;
        if (bus.hi !== 32'hA5A5A5A5 || bus.lo !== 32'hA5A5A5A5)
            $display("FAIL move_both got hi=%h lo=%h want a5a5a5a5 a5a5a5a5", bus.hi, bus.lo);
        else pass_cnt++;
        bus.mtlo = 1'b0; bus.wdata = 32'h11111111;
        step();
        bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.wdata = 32'h22222222;
        step();
        bus.mtlo = 1'b0;
        total_cnt++;
        if (bus.hi !== 32'h11111111 || bus.lo !== 32'h22222222)
            $display("FAIL move_single got hi=%h lo=%h want 11111111 22222222", bus.hi, bus.lo);
        else pass_cnt++;
    endtask

    task automatic test_start_with_mtlo();
        logic [31:0] hi, lo;
        logic dz, stable;
        int lat, busyc;
        bus.mtlo = 1'b1; bus.wdata = 32'hDEADBEEF;
        do_op(2'd1, 32'd10, 32'd20, hi, lo, dz, lat, busyc, stable);
        total_cnt++;
        if (hi !== 32'd0 || lo !== 32'd200 || stable !== 1'b1)
            $display("FAIL start_mtlo got hi=%h lo=%h stable=%b want 0 c8 1", hi, lo, stable);
        else pass_cnt++;
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] h1, l1, h2, l2;
        logic d1, d2, s1, s2;
        int lat1, lat2, b1, b2;
        do_op(2'd0, 32'hFFFFFFFE, 32'hFFFFFFFD, h1, l1, d1, lat1, b1, s1);
        do_op(2'd2, 32'd50, 32'hFFFFFFF9, h2, l2, d2, lat2, b2, s2);
        total_cnt++;
        if (h1 !== 32'd0 || l1 !== 32'd6 || lat1 !== 32)
            $display("FAIL b2b_first got hi=%h lo=%h lat=%0d want 0 6 32", h1, l1, lat1);
        else pass_cnt++;
        total_cnt++;
        if (h2 !== 32'd1 || l2 !== 32'hFFFFFFF9 || lat2 !== 32 || b2 !== 32)
            $display("FAIL b2b_second got hi=%h lo=%h lat=%0d busy=%0d want 1 fffffff9 32 32",
                     h2, l2, lat2, b2);
        else pass_cnt++;
        step();
    endtask

    task automatic test_random();
        logic [31:0] a, b, eh, el, hi, lo;
        logic [1:0] op;
        logic ed, dz, stable;
        int lat, busyc;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'h80000000;
            ref_model(op, a, b, eh, el, ed);
            do_op(op, a, b, hi, lo, dz, lat, busyc, stable);
            total_cnt++;
            if (hi !== eh || lo !== el || dz !== ed || lat !== 32)
                $display("FAIL rand%0d op=%0d a=%h b=%h got hi=%h lo=%h dz=%b lat=%0d want hi=%h lo=%h dz=%b lat=32",
                         i, op, a, b, hi, lo, dz, lat, eh, el, ed);
            else pass_cnt++;
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    initial begin
        test_reset();
        test_moves();
        test_vectors();
        test_reset_midrun();
        test_start_while_busy();
        test_start_with_mtlo();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
